// File: rtl/core_pkg.sv
// core_pkg: core-wide default widths and the CDB broadcast entry shared by
// the CDB arbiter and reservation stations.
package core_pkg;
  localparam int CORE_CDB_W  = 2;
  localparam int CORE_PHYS_W = 6;
  localparam int CORE_ROB_W  = 6;
  localparam int CORE_XLEN   = 64;

  typedef struct packed {
    logic [CORE_PHYS_W-1:0] tag;
    logic [CORE_XLEN-1:0]   value;
    logic [CORE_ROB_W-1:0]  rob_tag;
  } cdb_entry_t;

  // Index width that stays legal (>=1 bit) for single-entry structures
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fu_result_buf.sv
// fu_result_buf: per-FU FIFO holding completed results until a CDB lane
// is granted; occupancy is exposed so the producer sees registered backpressure.
module fu_result_buf import core_pkg::*; #(
  parameter type T     = cdb_entry_t,
  parameter int  DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  T                           i_data,
  input  logic                       i_pop,
  output T                           o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty
);
  localparam int AW = idx_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic          w_full, w_push, w_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
  assign w_push  = i_push && !w_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= w_push ? nxt(r_wr) : r_wr;
      r_rd    <= w_pop ? nxt(r_rd) : r_rd;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end

  // Payload needs no reset: an entry is only read after it has been written
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers FU results and grants up to CDB_W buffer heads per
// cycle in round-robin order onto registered CDB lanes.
module cdb_arbiter import core_pkg::*; #(
  parameter  int NUM_FU    = 4,
  parameter  int CDB_W     = CORE_CDB_W,
  parameter  int PHYS_W    = CORE_PHYS_W,
  parameter  int ROB_W     = CORE_ROB_W,
  parameter  int XLEN      = CORE_XLEN,
  parameter  int BUF_DEPTH = 2,
  localparam int FW        = idx_w(NUM_FU)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_FU-1:0]             fu_valid,
  output logic [NUM_FU-1:0]             fu_ready,
  input  logic [NUM_FU-1:0][PHYS_W-1:0] fu_dst_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]   fu_value,
  input  logic [NUM_FU-1:0][ROB_W-1:0]  fu_rob_tag,
  output logic [CDB_W-1:0]              cdb_valid,
  output logic [CDB_W-1:0][PHYS_W-1:0]  cdb_tag,
  output logic [CDB_W-1:0][XLEN-1:0]    cdb_value,
  output logic [CDB_W-1:0][ROB_W-1:0]   cdb_rob_tag,
  output logic [CDB_W-1:0][FW-1:0]      cdb_src_fu
);
  localparam int CW = $clog2(BUF_DEPTH+1);

  typedef struct packed {
    logic [PHYS_W-1:0] tag;
    logic [XLEN-1:0]   value;
    logic [ROB_W-1:0]  rob_tag;
  } entry_t;

  entry_t            w_in [NUM_FU];
  entry_t            w_head [NUM_FU];
  logic [CW-1:0]     w_count [NUM_FU];
  logic [NUM_FU-1:0] w_empty, w_push, w_grant;
  logic [CDB_W-1:0]  w_lane_v, w_go;
  logic [FW-1:0]     w_lane_fu [CDB_W];
  logic [FW-1:0]     w_idx, w_last, r_rr;
  int                w_n;

  assign w_push = fu_valid & fu_ready & {NUM_FU{~flush}};
  assign w_go   = w_lane_v & {CDB_W{~flush}};

  for (genvar f = 0; f < NUM_FU; f++) begin : g_buf
    // Ready comes from registered occupancy only; a same-cycle pop never credits it
    assign fu_ready[f] = w_count[f] < CW'(BUF_DEPTH);
    assign w_in[f] = '{tag: fu_dst_tag[f], value: fu_value[f], rob_tag: fu_rob_tag[f]};
    fu_result_buf #(.T(entry_t), .DEPTH(BUF_DEPTH)) u_buf (
      .clk     (clk),
      .rst_n   (reset),
      .i_flush (flush),
      .i_push  (w_push[f]),
      .i_data  (w_in[f]),
      .i_pop   (w_grant[f] & ~flush),
      .o_head  (w_head[f]),
      .o_count (w_count[f]),
      .o_empty (w_empty[f])
    );
  end

  // Walk FUs from rr_ptr; the k-th non-empty buffer found takes lane k
  always_comb begin
    w_grant   = '0;
    w_lane_v  = '0;
    w_lane_fu = '{default: '0};
    w_last    = r_rr;
    w_idx     = '0;
    w_n       = 0;
    for (int j = 0; j < NUM_FU; j++) begin
      w_idx = FW'((int'(r_rr) + j) % NUM_FU);
      if (!w_empty[w_idx] && w_n < CDB_W) begin
        w_grant[w_idx]  = 1'b1;
        w_lane_v[w_n]   = 1'b1;
        w_lane_fu[w_n]  = w_idx;
        w_last          = w_idx;
        w_n             = w_n + 1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_rr        <= '0;
      cdb_valid   <= '0;
      cdb_tag     <= '0;
      cdb_value   <= '0;
      cdb_rob_tag <= '0;
      cdb_src_fu  <= '0;
    end else begin
      r_rr <= flush ? '0 : !(|w_grant) ? r_rr : (w_last == FW'(NUM_FU-1)) ? '0 : w_last + 1'b1;
      for (int k = 0; k < CDB_W; k++) begin
        cdb_valid[k]   <= w_go[k];
        cdb_tag[k]     <= w_go[k] ? w_head[w_lane_fu[k]].tag : '0;
        cdb_value[k]   <= w_go[k] ? w_head[w_lane_fu[k]].value : '0;
        cdb_rob_tag[k] <= w_go[k] ? w_head[w_lane_fu[k]].rob_tag : '0;
        cdb_src_fu[k]  <= w_go[k] ? w_lane_fu[k] : '0;
      end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench; a queue-based reference model predicts each
// edge's CDB lanes, which are compared when the DUT presents them.
module tb_cdb_arbiter;
  typedef struct packed {logic [5:0] tag; logic [63:0] value; logic [5:0] rob;} ent_t;
  typedef struct packed {logic v; ent_t e; logic [1:0] src;} lane_t;
  typedef lane_t [1:0] lanes_t;

  logic             clk = 0, reset = 0, flush = 0;
  logic [3:0]       fu_valid = '0, fu_ready;
  logic [3:0][5:0]  fu_dst_tag = '0, fu_rob_tag = '0;
  logic [3:0][63:0] fu_value = '0;
  logic [1:0]       cdb_valid;
  logic [1:0][5:0]  cdb_tag, cdb_rob_tag;
  logic [1:0][63:0] cdb_value;
  logic [1:0][1:0]  cdb_src_fu;

  cdb_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_dst_tag(fu_dst_tag), .fu_value(fu_value), .fu_rob_tag(fu_rob_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_rob_tag(cdb_rob_tag), .cdb_src_fu(cdb_src_fu)
  );

  always #5 clk = ~clk;

  ent_t   pend [4][$];
  ent_t   mq [4][$];
  lanes_t sb [$];
  int     m_rr = 0, checks = 0, fails = 0, cyc = 0, maxgap = 0;
  int     gcnt [4], lastg [4];
  bit     hold = 0, cnt_en = 0, seen_nr1 = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cyc%0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic add(input int fu, input logic [5:0] tag, input logic [63:0] value, input logic [5:0] rob);
    pend[fu].push_back({tag, value, rob});
  endtask

  function automatic bit idle();
    for (int i = 0; i < 4; i++) if (pend[i].size() != 0 || mq[i].size() != 0) return 0;
    return 1;
  endfunction

  // Reference model of one clock edge, evaluated on the inputs about to be sampled
  task automatic model_step();
    lanes_t     l = '0;
    int         n = 0, last = -1, i;
    bit   [3:0] acc;
    ent_t       x;
    if (flush) begin
      for (int f = 0; f < 4; f++) mq[f].delete();
      m_rr = 0;
    end else begin
      for (int f = 0; f < 4; f++) acc[f] = fu_valid[f] && mq[f].size() < 2;
      for (int j = 0; j < 4; j++) begin
        i = (m_rr + j) % 4;
        if (mq[i].size() > 0 && n < 2) begin
          x = mq[i].pop_front();
          l[n] = {1'b1, x, 2'(i)};
          n++;
          last = i;
        end
      end
      for (int f = 0; f < 4; f++) if (acc[f]) mq[f].push_back({fu_dst_tag[f], fu_value[f], fu_rob_tag[f]});
      if (last >= 0) m_rr = (last + 1) % 4;
    end
    sb.push_back(l);
  endtask

  task automatic cycle(input bit fl = 0, input bit rel = 0);
    lanes_t     e;
    lane_t      o;
    logic [3:0] er;
    ent_t       x;
    @(negedge clk);
    cyc++;
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    for (int k = 0; k < 2; k++) begin
      o = {cdb_valid[k], cdb_tag[k], cdb_value[k], cdb_rob_tag[k], cdb_src_fu[k]};
      check($sformatf("%s%0d", reset ? "lane" : "rst_lane", k), o, e[k]);
      if (cnt_en && o.v) begin
        gcnt[o.src]++;
        if (lastg[o.src] >= 0 && cyc - lastg[o.src] > maxgap) maxgap = cyc - lastg[o.src];
        lastg[o.src] = cyc;
      end
    end
    for (int i = 0; i < 4; i++) er[i] = mq[i].size() < 2;
    check("fu_ready", fu_ready, er);
    if (!fu_ready[1]) seen_nr1 = 1;
    flush = fl;
    if (rel) begin
      reset = 1;
      hold  = 0;
    end
    for (int i = 0; i < 4; i++) begin
      x = '0;
      fu_valid[i] = hold;
      if (!hold && pend[i].size() > 0 && fu_ready[i]) begin
        x = pend[i].pop_front();
        fu_valid[i] = 1;
      end
      fu_dst_tag[i] = x.tag;
      fu_value[i]   = x.value;
      fu_rob_tag[i] = x.rob;
    end
    assert (!reset || !(|(fu_valid & ~fu_ready))) else $error("protocol: push while buffer not ready");
    if (reset) model_step();
  endtask

  task automatic wait_idle();
    int k = 0, left = 0;
    while (!idle() && k < 300) begin
      cycle();
      k++;
    end
    for (int i = 0; i < 4; i++) left += pend[i].size() + mq[i].size();
    check("drain", left, 0);
    repeat (3) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with every FU requesting
    hold = 1;
    repeat (3) cycle();
    cycle(0, 1);
    repeat (2) cycle();
    check("post_rst_ready", fu_ready, 4'hf);

    // Contention from rr_ptr=0: FU0/FU1 then FU2/FU3
    for (int i = 0; i < 4; i++) add(i, 6'(20 + i), 64'h100 + 64'(i), 6'(i + 1));
    wait_idle();

    // Single result on FU2; rr_ptr is back at 0
    add(2, 6'd10, 64'd8, 6'd0);
    wait_idle();

    // Saturation fairness
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 12; j++) add(i, 6'(i * 12 + j), {$urandom, $urandom}, 6'(j));
    repeat (4) cycle();
    for (int i = 0; i < 4; i++) begin
      gcnt[i]  = 0;
      lastg[i] = -1;
    end
    maxgap = 0;
    cnt_en = 1;
    repeat (8) cycle();
    cnt_en = 0;
    for (int i = 0; i < 4; i++) check($sformatf("grants_fu%0d", i), gcnt[i], 4);
    check("max_gap_le2", maxgap <= 2, 1);
    wait_idle();

    // Backpressure on FU1 behind other requesters
    seen_nr1 = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < ((i == 1) ? 3 : 4); j++) add(i, 6'(40 + i * 4 + j), {$urandom, $urandom}, 6'(32 + j));
    wait_idle();
    check("fu1_backpressure_seen", seen_nr1, 1);

    // Flush with entries buffered and a push in the flush cycle
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++) add(i, 6'(i * 3 + j), {$urandom, $urandom}, 6'(j + 8));
    cycle();
    cycle();
    cycle(1);
    cycle();
    check("flush_valid", cdb_valid, 2'b00);
    check("flush_ready", fu_ready, 4'hf);
    wait_idle();

    // Post-flush pushes from several FUs
    add(3, 6'd33, 64'hdead_beef, 6'd7);
    add(0, 6'd30, 64'h1234, 6'd5);
    add(1, 6'd31, 64'h5678, 6'd6);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
